sfp_tile_accum: RTL
===================

// Module: sfp_tile_accum
// PURPOSE
//  Parametrised successor of the per-column special-function stage. Sits between the last
//  MAC-array row and the output FIFO. Accumulates a programmable number of psum passes per
//  column into wide saturating accumulators, then applies optional ReLU and clamps to the
//  output width. Drains one output tile to the ofifo under a valid/ready handshake.
// PARAMETERS
//  col      8   number of columns/channels
//  psum_bw  16  signed width of each incoming psum
//  acc_bw   24  signed accumulator width, must be >= psum_bw
//  out_bw   16  signed width of each output word, must be <= acc_bw
//  cnt_bw   8   width of the pass counter and acc_len
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  reset      in   1            synchronous, active-low (0 = reset)
//  start      in   1            begin a tile; sampled only in IDLE
//  acc_len    in   cnt_bw       psum passes per column for this tile; latched on start
//  relu_en    in   1            1 = ReLU on output; latched on start
//  in_psum    in   psum_bw*col  psums from last MAC row, column k at [(k+1)*psum_bw-1:k*psum_bw]
//  valid_in   in   col          per-column psum valid
//  o_ready    in   1            ofifo can accept a tile
//  out_accum  out  out_bw*col   post-ReLU, clamped tile
//  o_valid    out  1            out_accum holds a tile
//  wr_ofifo   out  col          per-column ofifo write enable
//  busy       out  1            state != IDLE
//  done       out  1            one-cycle pulse when the tile is accepted
//  sat_flag   out  col          sticky per column: accumulator saturated this tile
// BEHAVIOUR
//  Reset (reset==0 at an edge): state=IDLE, accumulators, counters, sat_flag = 0.
//   o_valid, wr_ofifo, done, busy = 0. Reset wins over every other input, mid-tile included.
//   Partial tile is discarded.
//  FSM: IDLE -> ACCUM -> DRAIN -> IDLE.
//   IDLE:  start=1 latches acc_len (0 is treated as 1) and relu_en.
//          Clears accumulators, pass counters and sat_flag; next state ACCUM.
//          valid_in is ignored in IDLE.
//   ACCUM: at each edge, for every column k with valid_in[k]=1 and cnt[k] < len:
//          acc[k] <= sat(acc[k] + sext(in_psum[k])) and cnt[k] <= cnt[k]+1.
//          valid_in[k] is ignored once cnt[k]==len; extra psums are dropped silently.
//          Columns may complete on different cycles.
//          On the edge where every cnt reaches len (next-value check), state -> DRAIN.
//          Latency: the last psum is accumulated at that edge; o_valid=1 in the following cycle.
//   DRAIN: o_valid=1. out_accum[k] = clamp(relu_en ? max(acc[k],0) : acc[k]),
//          clamped to [-2^(out_bw-1), 2^(out_bw-1)-1].
//          wr_ofifo = {col{o_ready}} (all columns written together), combinational.
//          Transfer on o_valid & o_ready: next state IDLE, done=1 for that following cycle.
//          out_accum is held stable while o_ready=0. valid_in is ignored in DRAIN.
//  Saturation: a sum above 2^(acc_bw-1)-1 or below -2^(acc_bw-1) is pinned to that limit and
//   sets sat_flag[k]. The flag stays set until the next start or reset.
//  start while busy=1 is ignored. start and o_ready are independent of each other.
//  Outside DRAIN: o_valid=0, wr_ofifo=0, out_accum=0.
// TESTING
//  1 col=8, acc_len=3, relu_en=1, all columns psum=+5 on 3 consecutive cycles
//    -> out_accum every column=15; o_valid 1 cycle after the 3rd valid; done after o_ready.
//  2 relu_en=1, col0 psums -7,+2 -> col0 output 0; relu_en=0, same stimulus -> 0xFFFB.
//  3 staggered valid_in (col3 finishes 4 cycles late); extra pulses on finished columns
//    -> DRAIN entered only after col3 completes; extra psums do not change sums.
//  4 acc_bw=16, psum 0x7000 twice -> acc pinned at 0x7FFF, sat_flag[k]=1;
//    flag cleared by the next start.
//  5 o_ready=0 for 5 cycles in DRAIN -> o_valid held, out_accum stable, wr_ofifo=0;
//    o_ready=1 -> single write, done pulse, busy=0.
//  6 reset=0 asserted mid-ACCUM, and start with acc_len=0
//    -> reset: all outputs 0, state IDLE; acc_len=0: tile completes after one psum per column.

Source files
------------

// File: rtl/sfp_tile_accum.sv
`default_nettype none
// ============================================================================
// Module      : sfp_tile_accum
// Description : Per-column multi-pass psum accumulator with saturation, optional
//               ReLU and output clamping; drains one tile under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_tile_accum #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 24,
    parameter int OUT_BW  = 16,
    parameter int CNT_BW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_BW-1:0]      acc_len,
    input  logic                   relu_en,
    input  logic [PSUM_BW*COL-1:0] in_psum,
    input  logic [COL-1:0]         valid_in,
    input  logic                   o_ready,
    output logic [OUT_BW*COL-1:0]  out_accum,
    output logic                   o_valid,
    output logic [COL-1:0]         wr_ofifo,
    output logic                   busy,
    output logic                   done,
    output logic [COL-1:0]         sat_flag
);

    localparam logic [ACC_BW-1:0] c_ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] c_ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic [OUT_BW-1:0] c_OUT_MAX = {1'b0, {(OUT_BW-1){1'b1}}};
    localparam logic [OUT_BW-1:0] c_OUT_MIN = {1'b1, {(OUT_BW-1){1'b0}}};
    localparam int                c_EXT     = ACC_BW + 1 - PSUM_BW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BW-1:0]   len_q, len_d;
    logic                relu_q, relu_d;
    logic                done_q, done_d;
    logic [ACC_BW-1:0]   acc_q [COL];
    logic [ACC_BW-1:0]   acc_d [COL];
    logic [CNT_BW-1:0]   cnt_q [COL];
    logic [CNT_BW-1:0]   cnt_d [COL];
    logic [COL-1:0]      sat_q, sat_d;
    logic [COL-1:0]      w_col_full;
    logic                w_start, w_in_accum, w_in_drain;

    assign w_start    = (state_q == ST_IDLE) && start;
    assign w_in_accum = (state_q == ST_ACCUM);
    assign w_in_drain = (state_q == ST_DRAIN);

    generate
        for (genvar k = 0; k < COL; k++) begin : g_col
            logic [PSUM_BW-1:0]     w_psum;
            logic [ACC_BW:0]        w_sum;
            logic                   w_take;
            logic                   w_ovf;
            logic [ACC_BW-1:0]      w_acc_sat;
            logic [ACC_BW-1:0]      w_post_relu;
            logic [ACC_BW-OUT_BW:0] w_hi;
            logic [OUT_BW-1:0]      w_clamped;

            assign w_psum = in_psum[k*PSUM_BW +: PSUM_BW];
            // One guard bit: overflow shows up as the top two sum bits disagreeing.
            assign w_sum  = {acc_q[k][ACC_BW-1], acc_q[k]}
                          + {{c_EXT{w_psum[PSUM_BW-1]}}, w_psum};
            assign w_ovf  = w_sum[ACC_BW] ^ w_sum[ACC_BW-1];
            assign w_acc_sat = !w_ovf ? w_sum[ACC_BW-1:0]
                             : (w_sum[ACC_BW] ? c_ACC_MIN : c_ACC_MAX);

            assign w_take   = w_in_accum && valid_in[k] && (cnt_q[k] < len_q);
            assign cnt_d[k] = w_start ? '0 : (w_take ? cnt_q[k] + CNT_BW'(1) : cnt_q[k]);
            assign acc_d[k] = w_start ? '0 : (w_take ? w_acc_sat : acc_q[k]);
            assign sat_d[k] = w_start ? 1'b0 : (sat_q[k] | (w_take & w_ovf));
            assign w_col_full[k] = (cnt_d[k] == len_q);

            assign w_post_relu = (relu_q && acc_q[k][ACC_BW-1]) ? '0 : acc_q[k];
            // Value fits the output word when all bits from the output sign upward agree.
            assign w_hi      = w_post_relu[ACC_BW-1:OUT_BW-1];
            assign w_clamped = (&w_hi || ~|w_hi) ? w_post_relu[OUT_BW-1:0]
                             : (w_hi[ACC_BW-OUT_BW] ? c_OUT_MIN : c_OUT_MAX);
            assign out_accum[k*OUT_BW +: OUT_BW] = w_in_drain ? w_clamped : '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        relu_d  = relu_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (acc_len == '0) ? CNT_BW'(1) : acc_len;
                    relu_d  = relu_en;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (&w_col_full) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= '0;
            for (int k = 0; k < COL; k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            for (int k = 0; k < COL; k++) begin
                acc_q[k] <= acc_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_valid  = w_in_drain;
    assign wr_ofifo = {COL{w_in_drain & o_ready}};
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign sat_flag = sat_q;

endmodule
`default_nettype wire
